// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller.
//   alarm_state_e : per-channel FSM state encoding
//   Def*          : default parameter values used by alarm_ctrl / alarm_channel
package alarm_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDebounce,
        StAlarm,
        StHold,
        StSilenced
    } alarm_state_e;

    localparam int unsigned DefNumCh     = 3;
    localparam int unsigned DefDebounce  = 2;
    localparam int unsigned DefBeepHalf  = 4;
    localparam int unsigned DefEscCycles = 32;

endpackage

// File: rtl/alarm_channel.sv
// One independent sensor/buzzer channel: debounce, latched alarm, acknowledge,
// silence and escalation.
//   clk, reset : clock, asynchronous active-high reset
//   sensor     : raw sensor level
//   ack        : acknowledge level
//   buzzer     : registered buzzer drive
//   active     : registered, high in ALARM / HOLD / SILENCED
//   escalated  : registered, high once escalation fired until IDLE
module alarm_channel
    import alarm_pkg::*;
#(
    parameter int unsigned DEBOUNCE   = DefDebounce,
    parameter int unsigned BEEP_HALF  = DefBeepHalf,
    parameter int unsigned ESC_CYCLES = DefEscCycles
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor,
    input  logic ack,
    output logic buzzer,
    output logic active,
    output logic escalated
);

    localparam int unsigned DebW  = $clog2(DEBOUNCE + 1);
    localparam int unsigned BeepW = $clog2(BEEP_HALF + 1);
    localparam int unsigned EscW  = $clog2(ESC_CYCLES + 1);

    localparam logic [DebW-1:0]  DebMax   = DebW'(DEBOUNCE);
    localparam logic [BeepW-1:0] BeepLast = BeepW'(BEEP_HALF - 1);
    localparam logic [EscW-1:0]  EscMax   = EscW'(ESC_CYCLES);

    alarm_state_e    state_q, state_d;
    logic [DebW-1:0]  deb_q, deb_d;
    logic [BeepW-1:0] beep_q, beep_d;
    logic [EscW-1:0]  esc_q, esc_d;
    logic             buzzer_q, buzzer_d;
    logic             active_q, active_d;
    logic             escalated_q, escalated_d;

    logic go_idle;
    logic enter_alarm;

    always_comb begin
        state_d     = state_q;
        deb_d       = deb_q;
        beep_d      = beep_q;
        esc_d       = esc_q;
        buzzer_d    = buzzer_q;
        active_d    = active_q;
        escalated_d = escalated_q;
        go_idle     = 1'b0;
        enter_alarm = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (sensor) begin
                    if (DebMax == DebW'(1)) begin
                        enter_alarm = 1'b1;
                    end else begin
                        state_d = StDebounce;
                        deb_d   = DebW'(1);
                    end
                end
            end
            StDebounce: begin
                if (!sensor) begin
                    go_idle = 1'b1;
                end else if (deb_q + DebW'(1) >= DebMax) begin
                    enter_alarm = 1'b1;
                end else begin
                    deb_d = deb_q + DebW'(1);
                end
            end
            StAlarm, StHold: begin
                // ack with sensor low (or any ack in HOLD) clears outright
                if (ack && (state_q == StHold || !sensor)) begin
                    go_idle = 1'b1;
                end else if (ack) begin
                    state_d  = StSilenced;
                    buzzer_d = 1'b0;
                end else begin
                    state_d = sensor ? StAlarm : StHold;
                    // beep pattern and escalation continue across ALARM<->HOLD
                    if (beep_q == BeepLast) begin
                        beep_d   = '0;
                        buzzer_d = ~buzzer_q;
                    end else begin
                        beep_d = beep_q + BeepW'(1);
                    end
                    if (esc_q != EscMax) begin
                        esc_d = esc_q + EscW'(1);
                    end
                    if (esc_d == EscMax) begin
                        escalated_d = 1'b1;
                        buzzer_d    = 1'b1;
                    end
                end
            end
            StSilenced: begin
                if (!sensor) begin
                    go_idle = 1'b1;
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (go_idle) begin
            state_d     = StIdle;
            deb_d       = '0;
            beep_d      = '0;
            esc_d       = '0;
            buzzer_d    = 1'b0;
            active_d    = 1'b0;
            escalated_d = 1'b0;
        end
        if (enter_alarm) begin
            state_d     = StAlarm;
            deb_d       = '0;
            beep_d      = '0;
            esc_d       = '0;
            buzzer_d    = 1'b1;
            active_d    = 1'b1;
            escalated_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            deb_q       <= '0;
            beep_q      <= '0;
            esc_q       <= '0;
            buzzer_q    <= 1'b0;
            active_q    <= 1'b0;
            escalated_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            deb_q       <= deb_d;
            beep_q      <= beep_d;
            esc_q       <= esc_d;
            buzzer_q    <= buzzer_d;
            active_q    <= active_d;
            escalated_q <= escalated_d;
        end
    end

    assign buzzer    = buzzer_q;
    assign active    = active_q;
    assign escalated = escalated_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Multi-channel alarm controller: NUM_CH independent alarm_channel instances
// plus a registered any_alarm summary.
//   clk, reset : clock, asynchronous active-high reset
//   sensor     : per-channel raw sensor levels
//   ack        : per-channel acknowledge levels
//   buzzer     : per-channel buzzer drive
//   active     : per-channel alarm-active flags
//   escalated  : per-channel escalation flags
//   any_alarm  : OR of active, one cycle behind
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned NUM_CH     = DefNumCh,
    parameter int unsigned DEBOUNCE   = DefDebounce,
    parameter int unsigned BEEP_HALF  = DefBeepHalf,
    parameter int unsigned ESC_CYCLES = DefEscCycles
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] sensor,
    input  logic [NUM_CH-1:0] ack,
    output logic [NUM_CH-1:0] buzzer,
    output logic [NUM_CH-1:0] active,
    output logic [NUM_CH-1:0] escalated,
    output logic              any_alarm
);

    logic any_alarm_q, any_alarm_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        alarm_channel #(
            .DEBOUNCE   (DEBOUNCE),
            .BEEP_HALF  (BEEP_HALF),
            .ESC_CYCLES (ESC_CYCLES)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .sensor    (sensor[i]),
            .ack       (ack[i]),
            .buzzer    (buzzer[i]),
            .active    (active[i]),
            .escalated (escalated[i])
        );
    end

    always_comb begin
        any_alarm_d = |active;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            any_alarm_q <= 1'b0;
        end else begin
            any_alarm_q <= any_alarm_d;
        end
    end

    assign any_alarm = any_alarm_q;

endmodule
